rx_word_packer: RTL and testbench

Receive-side packing stage directly downstream of the serdes deserializer. It collects narrow words from the deserializer's parallel output (valid-only, no backpressure) into PACK_COUNT-lane wide words. It presents them on a valid/ready interface through a 2-entry output queue. Partial words can be flushed out, and words that cannot be queued are dropped and flagged with a sticky overflow.

---
 rtl/rx_word_packer_if.sv | 25 ++
 rtl/rx_word_packer.sv | 75 +++++++
 tb/tb_rx_word_packer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rx_word_packer_if.sv
// rx_word_packer_if: deserializer word input and packed-word queue output bundle.
interface rx_word_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_COUNT = 4
);
  localparam int CW = $clog2(PACK_COUNT + 1);
  logic [DATA_WIDTH-1:0]            data_in;
  logic                             valid_in;
  logic                             flush;
  logic [DATA_WIDTH*PACK_COUNT-1:0] word_out;
  logic [CW-1:0]                    count_out;
  logic                             valid_out;
  logic                             ready_in;
  logic                             overflow;
  logic                             overflow_clear;
  logic                             busy;
  modport master (
    output data_in, valid_in, flush, ready_in, overflow_clear,
    input  word_out, count_out, valid_out, overflow, busy
  );
  modport slave (
    input  data_in, valid_in, flush, ready_in, overflow_clear,
    output word_out, count_out, valid_out, overflow, busy
  );
endinterface

// File: rtl/rx_word_packer.sv
// rx_word_packer: packs deserializer words into PACK_COUNT-lane words behind a 2-entry output queue.
module rx_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_COUNT = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  rx_word_packer_if.slave bus
);
  localparam int CW = $clog2(PACK_COUNT + 1);
  localparam int WW = DATA_WIDTH * PACK_COUNT;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} q_state_e;
  q_state_e          state_q;
  logic [WW-1:0]     lanes_q, lanes_d, head_q, tail_q;
  logic [CW-1:0]     fill_q, fill_d, idx, head_cnt_q, tail_cnt_q, push_cnt;
  logic              complete, push, pop, ovf_q;
  always_comb begin
    idx = MSB_FIRST ? CW'(PACK_COUNT - 1) - fill_q : fill_q;
    lanes_d = lanes_q;
    for (int i = 0; i < PACK_COUNT; i++)
      if (bus.valid_in && idx == CW'(i)) lanes_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.data_in;
    complete = bus.valid_in && fill_q == CW'(PACK_COUNT - 1);
    fill_d = complete ? '0 : fill_q + CW'(bus.valid_in);
    // flush sees the fill after this cycle's word, so a completing word never flushes empty
    push = complete || (bus.flush && fill_d != '0);
    push_cnt = complete ? CW'(PACK_COUNT) : fill_d;
    pop = bus.valid_out && bus.ready_in;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lanes_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      head_cnt_q <= '0;
      tail_cnt_q <= '0;
      ovf_q      <= 1'b0;
      state_q    <= EMPTY;
    end else begin
      lanes_q <= push ? '0 : lanes_d;
      fill_q  <= push ? '0 : fill_d;
      ovf_q   <= (push && state_q == TWO && !pop) || (ovf_q && !bus.overflow_clear);
      case (state_q)
        EMPTY: if (push) begin
          head_q     <= lanes_d;
          head_cnt_q <= push_cnt;
          state_q    <= ONE;
        end
        ONE: if (pop) begin
          head_q     <= push ? lanes_d : '0;
          head_cnt_q <= push ? push_cnt : '0;
          state_q    <= push ? ONE : EMPTY;
        end else if (push) begin
          tail_q     <= lanes_d;
          tail_cnt_q <= push_cnt;
          state_q    <= TWO;
        end
        TWO: if (pop) begin
          head_q     <= tail_q;
          head_cnt_q <= tail_cnt_q;
          tail_q     <= push ? lanes_d : '0;
          tail_cnt_q <= push ? push_cnt : '0;
          state_q    <= push ? TWO : ONE;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end
  assign bus.word_out  = head_q;
  assign bus.count_out = head_cnt_q;
  assign bus.valid_out = state_q != EMPTY;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = fill_q != '0;
endmodule

// File: tb/tb_rx_word_packer.sv
// tb_rx_word_packer: directed checks of packing, flush, queue backpressure/overflow and reset.
module tb_rx_word_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] data = '0;
  logic valid = 1'b0, flush = 1'b0, ready = 1'b1, clr = 1'b0;
  int total = 0, bad = 0;
  rx_word_packer_if #(.DATA_WIDTH(8), .PACK_COUNT(4)) bus0 ();
  rx_word_packer_if #(.DATA_WIDTH(8), .PACK_COUNT(4)) bus1 ();
  assign bus0.data_in = data;
  assign bus0.valid_in = valid;
  assign bus0.flush = flush;
  assign bus0.ready_in = ready;
  assign bus0.overflow_clear = clr;
  assign bus1.data_in = data;
  assign bus1.valid_in = valid;
  assign bus1.flush = flush;
  assign bus1.ready_in = ready;
  assign bus1.overflow_clear = clr;
  rx_word_packer #(.DATA_WIDTH(8), .PACK_COUNT(4), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(bus0));
  rx_word_packer #(.DATA_WIDTH(8), .PACK_COUNT(4), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(bus1));
  always #5 clk = ~clk;
  task automatic cyc(input logic v, input logic [7:0] d, input logic f);
    valid = v;
    data = d;
    flush = f;
    @(posedge clk);
    #1;
    valid = 1'b0;
    flush = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    chk("rst_word", 64'(bus0.word_out), 64'h0);
    chk("rst_count", 64'(bus0.count_out), 64'h0);
    chk("rst_valid", 64'(bus0.valid_out), 64'h0);
    chk("rst_ovf", 64'(bus0.overflow), 64'h0);
    chk("rst_busy", 64'(bus0.busy), 64'h0);
    rst_n = 1'b1;
    cyc(1, 8'h11, 0);
    cyc(1, 8'h22, 0);
    cyc(1, 8'h33, 0);
    chk("t1_busy_mid", 64'(bus0.busy), 64'h1);
    chk("t1_novalid_mid", 64'(bus0.valid_out), 64'h0);
    cyc(1, 8'h44, 0);
    chk("t1_valid", 64'(bus0.valid_out), 64'h1);
    chk("t1_word", 64'(bus0.word_out), 64'h11223344);
    chk("t1_count", 64'(bus0.count_out), 64'h4);
    chk("t1_busy", 64'(bus0.busy), 64'h0);
    chk("t1_lsb_word", 64'(bus1.word_out), 64'h44332211);
    cyc(0, 8'h00, 0);
    chk("t1_pulse", 64'(bus0.valid_out), 64'h0);
    chk("t1_empty_word", 64'(bus0.word_out), 64'h0);
    cyc(1, 8'hAA, 0);
    cyc(1, 8'hBB, 0);
    cyc(0, 8'h00, 1);
    chk("t2_valid", 64'(bus0.valid_out), 64'h1);
    chk("t2_word", 64'(bus0.word_out), 64'hAABB0000);
    chk("t2_count", 64'(bus0.count_out), 64'h2);
    chk("t2_busy", 64'(bus0.busy), 64'h0);
    chk("t2_lsb_word", 64'(bus1.word_out), 64'h0000BBAA);
    cyc(0, 8'h00, 1);
    chk("t2_empty_flush", 64'(bus0.valid_out), 64'h0);
    cyc(0, 8'h00, 0);
    chk("t2_empty_flush2", 64'(bus0.valid_out), 64'h0);
    cyc(1, 8'h01, 0);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h03, 0);
    cyc(1, 8'h04, 1);
    chk("t3_valid", 64'(bus0.valid_out), 64'h1);
    chk("t3_word", 64'(bus0.word_out), 64'h01020304);
    chk("t3_count", 64'(bus0.count_out), 64'h4);
    cyc(0, 8'h00, 0);
    chk("t3_no_second", 64'(bus0.valid_out), 64'h0);
    ready = 1'b0;
    for (int i = 0; i < 11; i++) cyc(1, 8'(i), 0);
    clr = 1'b1;
    cyc(1, 8'h0B, 0);
    clr = 1'b0;
    chk("t4_ovf_set_wins", 64'(bus0.overflow), 64'h1);
    chk("t4_head", 64'(bus0.word_out), 64'h00010203);
    chk("t4_valid", 64'(bus0.valid_out), 64'h1);
    chk("t4_busy", 64'(bus0.busy), 64'h0);
    cyc(0, 8'h00, 0);
    chk("t4_stable", 64'(bus0.word_out), 64'h00010203);
    ready = 1'b1;
    cyc(0, 8'h00, 0);
    chk("t4_drain1_valid", 64'(bus0.valid_out), 64'h1);
    chk("t4_drain1_word", 64'(bus0.word_out), 64'h04050607);
    cyc(0, 8'h00, 0);
    chk("t4_drain2_valid", 64'(bus0.valid_out), 64'h0);
    chk("t4_ovf_sticky", 64'(bus0.overflow), 64'h1);
    clr = 1'b1;
    cyc(0, 8'h00, 0);
    clr = 1'b0;
    chk("t4_ovf_clear", 64'(bus0.overflow), 64'h0);
    ready = 1'b0;
    for (int i = 16; i < 27; i++) cyc(1, 8'(i), 0);
    chk("t5_full_head", 64'(bus0.word_out), 64'h10111213);
    ready = 1'b1;
    cyc(1, 8'h1B, 0);
    chk("t5_no_ovf", 64'(bus0.overflow), 64'h0);
    chk("t5_head", 64'(bus0.word_out), 64'h14151617);
    cyc(0, 8'h00, 0);
    chk("t5_head2", 64'(bus0.word_out), 64'h18191A1B);
    chk("t5_count2", 64'(bus0.count_out), 64'h4);
    cyc(0, 8'h00, 0);
    chk("t5_drained", 64'(bus0.valid_out), 64'h0);
    cyc(1, 8'h55, 0);
    cyc(1, 8'h66, 0);
    rst_n = 1'b0;
    cyc(0, 8'h00, 0);
    rst_n = 1'b1;
    chk("t6_rst_busy", 64'(bus0.busy), 64'h0);
    cyc(1, 8'h11, 0);
    cyc(1, 8'h22, 0);
    cyc(1, 8'h33, 0);
    cyc(1, 8'h44, 0);
    chk("t6_msb_word", 64'(bus0.word_out), 64'h11223344);
    chk("t6_lsb_word", 64'(bus1.word_out), 64'h44332211);
    chk("t6_count", 64'(bus1.count_out), 64'h4);
    cyc(0, 8'h00, 0);
    chk("t6_done", 64'(bus0.valid_out), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
